// File: rtl/pipeline_run_ctrl_pkg.sv
// pipeline_run_ctrl_pkg: shared encodings for the pipeline run controller.
package pipeline_run_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_LOAD = 3'd1, S_WARMUP = 3'd2, S_RUN = 3'd3, S_STEP = 3'd4, S_HALTED = 3'd5} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'd0, OP_RUN = 2'd1, OP_STEP = 2'd2, OP_STOP = 2'd3} op_t;
  typedef enum logic [1:0] {HR_NONE = 2'd0, HR_HALT = 2'd1, HR_LIMIT = 2'd2, HR_STOP = 2'd3} halt_t;
  localparam logic [31:0] PC_LIMIT_DEFAULT = 32'h0000_07FF;
endpackage

// File: rtl/pipeline_run_ctrl_counter.sv
// sat_counter32: 32-bit event counter with synchronous clear, saturating at all-ones.
module sat_counter32 (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count
);
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != 32'hFFFF_FFFF) count <= count + 32'd1;
endmodule

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: load/warmup/run/step/halt sequencer for the pipeline PC and instruction memory.
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_LIMIT      = PC_LIMIT_DEFAULT,
  parameter int          WARMUP_CYCLES = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  input  logic        load_word_valid,
  input  logic        load_done,
  input  logic        halt_detected,
  input  logic [31:0] pc_value,
  output logic        pc_enable,
  output logic        pipe_flush,
  output logic        imem_we,
  output logic [9:0]  load_addr,
  output logic [2:0]  state,
  output logic [1:0]  halt_reason,
  output logic        step_done,
  output logic [31:0] cycle_count
);
  state_t      st;
  halt_t       hr;
  op_t         op;
  logic        mode_step, acc, at_limit, clear;
  logic [31:0] wcnt;
  assign op        = op_t'(cmd_op);
  assign cmd_ready = st == S_IDLE || st == S_HALTED || st == S_RUN;
  assign acc       = cmd_valid && cmd_ready;
  assign at_limit  = pc_value >= PC_LIMIT;
  assign pc_enable = st == S_RUN || st == S_STEP;
  assign imem_we   = st == S_LOAD && load_word_valid;
  assign state     = st;
  assign halt_reason = hr;
  assign clear = acc && st != S_RUN && (op == OP_LOAD || (st == S_IDLE && (op == OP_RUN || op == OP_STEP)));
  sat_counter32 u_cnt (.Clock(Clock), .Reset(Reset), .clear(clear), .inc(pc_enable), .count(cycle_count));
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      st         <= S_IDLE;
      hr         <= HR_NONE;
      mode_step  <= 1'b0;
      wcnt       <= '0;
      pipe_flush <= 1'b0;
      load_addr  <= '0;
      step_done  <= 1'b0;
    end else begin
      pipe_flush <= 1'b0;
      step_done  <= 1'b0;
      case (st)
        S_IDLE:
          if (acc && op == OP_LOAD) begin
            st         <= S_LOAD;
            pipe_flush <= 1'b1;
            load_addr  <= '0;
          end else if (acc && (op == OP_RUN || op == OP_STEP)) begin
            st         <= S_WARMUP;
            mode_step  <= op == OP_STEP;
            wcnt       <= '0;
            pipe_flush <= 1'b1;
            hr         <= HR_NONE;
          end
        S_LOAD: begin
          if (load_word_valid) load_addr <= load_addr + 10'd1;
          if (load_done) st <= S_IDLE;
        end
        S_WARMUP:
          if (wcnt == 32'(WARMUP_CYCLES - 1)) begin
            st <= at_limit ? S_HALTED : mode_step ? S_STEP : S_RUN;
            hr <= at_limit ? HR_LIMIT : HR_NONE;
          end else begin
            wcnt       <= wcnt + 32'd1;
            pipe_flush <= 1'b1;
          end
        S_RUN:
          if (halt_detected || at_limit || (acc && op == OP_STOP)) begin
            st <= S_HALTED;
            hr <= halt_detected ? HR_HALT : at_limit ? HR_LIMIT : HR_STOP;
          end
        S_STEP: begin
          st        <= S_HALTED;
          step_done <= 1'b1;
          hr        <= halt_detected ? HR_HALT : HR_NONE;
        end
        S_HALTED:
          if (acc && op == OP_LOAD) begin
            st         <= S_LOAD;
            pipe_flush <= 1'b1;
            load_addr  <= '0;
          end else if (acc && op == OP_STOP) st <= S_IDLE;
          else if (acc) begin
            st <= at_limit ? S_HALTED : op == OP_STEP ? S_STEP : S_RUN;
            hr <= at_limit ? HR_LIMIT : HR_NONE;
          end
        default: st <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// tb_pipeline_run_ctrl: directed checks of load, warmup, run/step, stop causes and reset abort.
module tb_pipeline_run_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic        cmd_ready;
  logic        load_word_valid = 1'b0;
  logic        load_done = 1'b0;
  logic        halt_detected = 1'b0;
  logic [31:0] pc_value = '0;
  logic        pc_enable, pipe_flush, imem_we, step_done;
  logic [9:0]  load_addr;
  logic [2:0]  state;
  logic [1:0]  halt_reason;
  logic [31:0] cycle_count;
  int checks = 0;
  int errors = 0;
  pipeline_run_ctrl dut (
    .Clock(clk), .Reset(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .load_word_valid(load_word_valid), .load_done(load_done), .halt_detected(halt_detected),
    .pc_value(pc_value), .pc_enable(pc_enable), .pipe_flush(pipe_flush), .imem_we(imem_we),
    .load_addr(load_addr), .state(state), .halt_reason(halt_reason), .step_done(step_done),
    .cycle_count(cycle_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc_en", 32'(pc_enable), 0);
    chk("rst_flush", 32'(pipe_flush), 0);
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(load_addr), 0);
    chk("rst_reason", 32'(halt_reason), 0);
    chk("rst_stepdone", 32'(step_done), 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    rst = 1'b0;
    tick();
    chk("post_rst_state", 32'(state), 0);
    // LOAD four words then load_done
    cmd(2'd0);
    chk("load_state", 32'(state), 1);
    chk("load_flush", 32'(pipe_flush), 1);
    chk("load_ready", 32'(cmd_ready), 0);
    for (int i = 0; i < 4; i++) begin
      load_word_valid = 1'b1;
      #1;
      chk("load_we", 32'(imem_we), 1);
      chk("load_addr", 32'(load_addr), i);
      tick();
      if (i == 0) chk("load_flush_off", 32'(pipe_flush), 0);
    end
    load_word_valid = 1'b0;
    #1;
    chk("load_we_idle", 32'(imem_we), 0);
    chk("load_addr_end", 32'(load_addr), 4);
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk("load_back_idle", 32'(state), 0);
    // RUN from IDLE with HALT at enabled cycle 10
    cmd(2'd1);
    chk("warm_state1", 32'(state), 2);
    chk("warm_flush1", 32'(pipe_flush), 1);
    chk("warm_pc_en1", 32'(pc_enable), 0);
    tick();
    chk("warm_state2", 32'(state), 2);
    chk("warm_flush2", 32'(pipe_flush), 1);
    tick();
    chk("run_state", 32'(state), 3);
    chk("run_flush", 32'(pipe_flush), 0);
    chk("run_pc_en", 32'(pc_enable), 1);
    chk("run_ready", 32'(cmd_ready), 1);
    repeat (9) tick();
    chk("run_count9", cycle_count, 9);
    halt_detected = 1'b1;
    tick();
    halt_detected = 1'b0;
    chk("halt_state", 32'(state), 5);
    chk("halt_reason", 32'(halt_reason), 1);
    chk("halt_pc_en", 32'(pc_enable), 0);
    chk("halt_count", cycle_count, 10);
    // HALTED -> RUN directly, then HALT and STOP together
    cmd(2'd1);
    chk("rerun_state", 32'(state), 3);
    chk("rerun_count", cycle_count, 10);
    halt_detected = 1'b1;
    cmd(2'd3);
    halt_detected = 1'b0;
    chk("prio_state", 32'(state), 5);
    chk("prio_reason", 32'(halt_reason), 1);
    chk("prio_count", cycle_count, 11);
    // three STEPs, the last with HALT sampled during the step
    for (int i = 0; i < 3; i++) begin
      cmd(2'd2);
      chk("step_state", 32'(state), 4);
      chk("step_pc_en", 32'(pc_enable), 1);
      chk("step_ready", 32'(cmd_ready), 0);
      chk("step_done_lo", 32'(step_done), 0);
      if (i == 2) halt_detected = 1'b1;
      tick();
      halt_detected = 1'b0;
      chk("step_halted", 32'(state), 5);
      chk("step_done_hi", 32'(step_done), 1);
      chk("step_pc_off", 32'(pc_enable), 0);
      chk("step_reason", 32'(halt_reason), i == 2 ? 1 : 0);
    end
    chk("step_count", cycle_count, 14);
    tick();
    chk("step_done_drop", 32'(step_done), 0);
    // STOP to IDLE, then RUN into the PC limit
    cmd(2'd3);
    chk("stop_idle", 32'(state), 0);
    cmd(2'd1);
    chk("warm_reason_clr", 32'(halt_reason), 0);
    chk("warm_count_clr", cycle_count, 0);
    repeat (2) tick();
    chk("lim_run", 32'(state), 3);
    pc_value = 32'h7FD;
    tick();
    pc_value = 32'h7FE;
    tick();
    pc_value = 32'h7FF;
    #1;
    chk("lim_pc_en_still", 32'(pc_enable), 1);
    tick();
    chk("lim_pc_en_off", 32'(pc_enable), 0);
    chk("lim_state", 32'(state), 5);
    chk("lim_reason", 32'(halt_reason), 2);
    chk("lim_count", cycle_count, 3);
    // entering RUN/STEP while already at the limit
    cmd(2'd1);
    chk("lim_run_blk", 32'(state), 5);
    chk("lim_run_pc", 32'(pc_enable), 0);
    chk("lim_run_reason", 32'(halt_reason), 2);
    cmd(2'd2);
    chk("lim_step_blk", 32'(state), 5);
    chk("lim_step_pc", 32'(pc_enable), 0);
    pc_value = '0;
    // RUN ignores LOAD, STOP gives reason 11
    cmd(2'd1);
    chk("run2_state", 32'(state), 3);
    cmd(2'd0);
    chk("run_ignores_load", 32'(state), 3);
    cmd(2'd3);
    chk("stop_state", 32'(state), 5);
    chk("stop_reason", 32'(halt_reason), 3);
    // reset mid-RUN
    cmd(2'd1);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("rstrun_pc_en", 32'(pc_enable), 0);
    chk("rstrun_state", 32'(state), 0);
    chk("rstrun_count", cycle_count, 0);
    rst = 1'b0;
    tick();
    chk("rstrun_ready", 32'(cmd_ready), 1);
    // reset mid-LOAD kills imem_we
    cmd(2'd0);
    load_word_valid = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    chk("rstload_we", 32'(imem_we), 0);
    chk("rstload_addr", 32'(load_addr), 0);
    load_word_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("rstload_state", 32'(state), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
